// File: rtl/i2c_slave_responder.sv
// I2C slave responder at a fixed 7-bit address: ACKs writes into a receive memory and serves
// reads from a host-loaded transmit FIFO, reporting each finished transfer on a status strobe.
module i2c_slave_responder #(
    parameter int unsigned                    I2C_ADDR_WIDTH = 7,
    parameter int unsigned                    I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0]      SLAVE_ADDR     = 7'h12,
    parameter int unsigned                    RX_DEPTH       = 128,
    parameter int unsigned                    TX_DEPTH       = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              scl_i,
    input  logic                              sda_i,
    output logic                              sda_o,
    input  logic                              tx_push,
    input  logic [I2C_DATA_WIDTH-1:0]         tx_data,
    output logic                              tx_empty,
    input  logic [$clog2(RX_DEPTH)-1:0]       rx_idx,
    output logic [I2C_DATA_WIDTH-1:0]         rx_data,
    output logic [$clog2(RX_DEPTH+1)-1:0]     rx_count,
    output logic                              xfer_done,
    output logic                              xfer_op,
    output logic [7:0]                        xfer_len
);

    localparam int unsigned DW     = I2C_DATA_WIDTH;
    localparam int unsigned RxIdxW = $clog2(RX_DEPTH);
    localparam int unsigned RxCntW = $clog2(RX_DEPTH + 1);
    localparam int unsigned TxPtrW = $clog2(TX_DEPTH);
    localparam int unsigned TxCntW = $clog2(TX_DEPTH + 1);
    localparam logic [RxCntW-1:0] RxFull = RxCntW'(RX_DEPTH);
    localparam logic [TxCntW-1:0] TxFull = TxCntW'(TX_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrData, StWrAck, StRdData, StRdAck, StIgnore
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          scl_sync_q, sda_sync_q;
    logic                scl_prev_q, sda_prev_q;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]       shift_q, shift_d;
    logic [DW-1:0]       tx_shift_q, tx_shift_d;
    logic                sda_out_q, sda_out_d;
    logic                rw_q, rw_d;
    logic                addressed_q, addressed_d;
    logic [7:0]          len_q, len_d;
    logic                done_q, done_d;
    logic                op_q, op_d;
    logic [7:0]          xlen_q, xlen_d;
    logic [RxCntW-1:0]   rx_count_q;
    logic                rx_we;

    logic [DW-1:0]       rx_mem [RX_DEPTH];
    logic [DW-1:0]       tx_mem [TX_DEPTH];
    logic [TxPtrW-1:0]   tx_wr_ptr_q, tx_rd_ptr_q;
    logic [TxCntW-1:0]   tx_cnt_q;
    logic                tx_pop, tx_pop_eff, tx_push_eff, tx_empty_w, tx_full_w;
    logic [DW-1:0]       tx_byte;

    logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

    assign scl       = scl_sync_q[1];
    assign sda       = sda_sync_q[1];
    assign scl_rise  = scl & ~scl_prev_q;
    assign scl_fall  = ~scl & scl_prev_q;
    assign start_det = scl & scl_prev_q & ~sda & sda_prev_q;
    assign stop_det  = scl & scl_prev_q & sda & ~sda_prev_q;

    assign tx_empty_w  = (tx_cnt_q == '0);
    assign tx_full_w   = (tx_cnt_q == TxFull);
    assign tx_pop_eff  = tx_pop & ~tx_empty_w;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign tx_push_eff = tx_push & (~tx_full_w | tx_pop_eff);
    assign tx_byte     = tx_empty_w ? '1 : tx_mem[tx_rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        sda_out_d   = sda_out_q;
        rw_d        = rw_q;
        addressed_d = addressed_q;
        len_d       = len_q;
        done_d      = 1'b0;
        op_d        = op_q;
        xlen_d      = xlen_q;
        rx_we       = 1'b0;
        tx_pop      = 1'b0;

        if (start_det || stop_det) begin
            if (addressed_q) begin
                done_d = 1'b1;
                op_d   = rw_q;
                xlen_d = len_q;
            end
            addressed_d = 1'b0;
            sda_out_d   = 1'b1;
            bit_cnt_d   = '0;
            if (start_det) begin
                state_d = StAddr;
                len_d   = '0;
            end else begin
                state_d = StIdle;
            end
        end else begin
            case (state_q)
                StAddr, StWrData: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[DW-2:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state_q == StAddr) begin
                            if (shift_q[DW-1:1] == SLAVE_ADDR) begin
                                state_d     = StAddrAck;
                                sda_out_d   = 1'b0;
                                addressed_d = 1'b1;
                                rw_d        = shift_q[0];
                            end else begin
                                state_d = StIgnore;
                            end
                        end else begin
                            rx_we     = (rx_count_q != RxFull);
                            len_d     = (len_q == 8'hFF) ? len_q : len_q + 8'd1;
                            state_d   = StWrAck;
                            sda_out_d = 1'b0;
                        end
                    end
                end
                StAddrAck, StWrAck: begin
                    if (scl_rise) begin
                        bit_cnt_d = 4'd1;
                    end else if (scl_fall && bit_cnt_q != '0) begin
                        bit_cnt_d = '0;
                        if (state_q == StWrAck || !rw_q) begin
                            state_d   = StWrData;
                            sda_out_d = 1'b1;
                        end else begin
                            // MSB must be on the bus before the next rising edge.
                            state_d    = StRdData;
                            tx_pop     = 1'b1;
                            tx_shift_d = tx_byte;
                            sda_out_d  = tx_byte[DW-1];
                        end
                    end
                end
                StRdData: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_out_d = 1'b1;
                            bit_cnt_d = '0;
                            len_d     = (len_q == 8'hFF) ? len_q : len_q + 8'd1;
                            state_d   = StRdAck;
                        end else if (bit_cnt_q != '0) begin
                            sda_out_d  = tx_shift_q[DW-2];
                            tx_shift_d = tx_shift_q << 1;
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        bit_cnt_d  = 4'd1;
                        shift_d[0] = sda;
                    end else if (scl_fall && bit_cnt_q != '0) begin
                        bit_cnt_d = '0;
                        if (shift_q[0]) begin
                            state_d = StIgnore;
                        end else begin
                            state_d    = StRdData;
                            tx_pop     = 1'b1;
                            tx_shift_d = tx_byte;
                            sda_out_d  = tx_byte[DW-1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            scl_sync_q  <= 2'b11;
            sda_sync_q  <= 2'b11;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_shift_q  <= '0;
            sda_out_q   <= 1'b1;
            rw_q        <= 1'b0;
            addressed_q <= 1'b0;
            len_q       <= '0;
            done_q      <= 1'b0;
            op_q        <= 1'b0;
            xlen_q      <= '0;
            rx_count_q  <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= {scl_sync_q[0], scl_i};
            sda_sync_q  <= {sda_sync_q[0], sda_i};
            scl_prev_q  <= scl;
            sda_prev_q  <= sda;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_shift_q  <= tx_shift_d;
            sda_out_q   <= sda_out_d;
            rw_q        <= rw_d;
            addressed_q <= addressed_d;
            len_q       <= len_d;
            done_q      <= done_d;
            op_q        <= op_d;
            xlen_q      <= xlen_d;
            if (rx_we) rx_count_q <= rx_count_q + RxCntW'(1);
            if (tx_push_eff) tx_wr_ptr_q <= tx_wr_ptr_q + TxPtrW'(1);
            if (tx_pop_eff) tx_rd_ptr_q <= tx_rd_ptr_q + TxPtrW'(1);
            case ({tx_push_eff, tx_pop_eff})
                2'b10:   tx_cnt_q <= tx_cnt_q + TxCntW'(1);
                2'b01:   tx_cnt_q <= tx_cnt_q - TxCntW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_we) rx_mem[rx_count_q[RxIdxW-1:0]] <= shift_q;
        if (tx_push_eff) tx_mem[tx_wr_ptr_q] <= tx_data;
    end

    assign sda_o     = sda_out_q;
    assign tx_empty  = tx_empty_w;
    assign rx_data   = rx_mem[rx_idx];
    assign rx_count  = rx_count_q;
    assign xfer_done = done_q;
    assign xfer_op   = op_q;
    assign xfer_len  = xlen_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master on a wired-AND bus, with scoreboard queues for
// read data and transfer-done reports.
module tb_i2c_slave_responder;

    localparam int Q = 5;  // quarter SCL period in clk cycles (SCL = clk/20)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_o;
    logic       tx_push = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_empty;
    logic [6:0] rx_idx = '0;
    logic [7:0] rx_data;
    logic [7:0] rx_count;
    logic       xfer_done;
    logic       xfer_op;
    logic [7:0] xfer_len;
    logic       sda_bus;

    assign sda_bus = sda_m & sda_o;

    i2c_slave_responder dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_o     (sda_o),
        .tx_push   (tx_push),
        .tx_data   (tx_data),
        .tx_empty  (tx_empty),
        .rx_idx    (rx_idx),
        .rx_data   (rx_data),
        .rx_count  (rx_count),
        .xfer_done (xfer_done),
        .xfer_op   (xfer_op),
        .xfer_len  (xfer_len)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;
    int done_seen = 0;
    logic [7:0] rd_q[$];
    logic [8:0] done_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (xfer_done) begin
            logic [8:0] e;
            done_seen++;
            check("done_expected", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) begin
                e = done_q.pop_front();
                check("xfer_op", 32'(xfer_op), 32'(e[8]));
                check("xfer_len", 32'(xfer_len), 32'(e[7:0]));
            end
        end
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic start_c();
        if (!scl) begin
            sda_m = 1'b1; wq();
            scl = 1'b1;   wq();
        end
        sda_m = 1'b0; wq();
        scl = 1'b0;   wq();
    endtask

    task automatic stop_c();
        sda_m = 1'b0; wq();
        scl = 1'b1;   wq();
        sda_m = 1'b1; wq(); wq();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wq();
        scl = 1'b1; wq(); wq();
        scl = 1'b0; wq();
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wq();
        scl = 1'b1;   wq();
        b = sda_bus;  wq();
        scl = 1'b0;   wq();
    endtask

    task automatic send_byte(input logic [7:0] d, input string tag, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        check(tag, 32'(a), 32'(exp_ack));
    endtask

    task automatic read_check(input logic nack);
        logic [7:0] d;
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
        check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) check("rd_data", 32'(d), 32'(rd_q.pop_front()));
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data = d;
        tx_push = 1'b1;
        @(negedge clk);
        tx_push = 1'b0;
    endtask

    initial begin
        int n0;
        logic b;

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sda_o", 32'(sda_o), 32'd1);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_tx_empty", 32'(tx_empty), 32'd1);
        check("rst_xfer_done", 32'(xfer_done), 32'd0);
        check("rst_xfer_op", 32'(xfer_op), 32'd0);
        check("rst_xfer_len", 32'(xfer_len), 32'd0);

        // Write 32 bytes
        start_c();
        send_byte(8'h24, "wr_addr_ack", 1'b0);
        for (int i = 0; i < 32; i++) send_byte(8'(i), "wr_ack", 1'b0);
        done_q.push_back({1'b0, 8'd32});
        stop_c();
        wq();
        check("wr32_rx_count", 32'(rx_count), 32'd32);
        for (int i = 0; i < 32; i++) begin
            rx_idx = 7'(i);
            #1 check("wr32_rx_mem", 32'(rx_data), 32'(i));
        end

        // Read 32 bytes
        for (int i = 0; i < 32; i++) begin
            push_tx(8'(100 + i));
            rd_q.push_back(8'(100 + i));
        end
        check("rd32_tx_not_empty", 32'(tx_empty), 32'd0);
        start_c();
        send_byte(8'h25, "rd_addr_ack", 1'b0);
        for (int i = 0; i < 32; i++) read_check(i == 31);
        done_q.push_back({1'b1, 8'd32});
        stop_c();
        wq();
        check("rd32_tx_empty", 32'(tx_empty), 32'd1);

        // Alternating write/read with repeated STARTs
        n0 = done_seen;
        for (int k = 63; k >= 0; k--) begin
            push_tx(8'(k));
            rd_q.push_back(8'(k));
        end
        for (int it = 0; it < 64; it++) begin
            if (it > 0) done_q.push_back({1'b1, 8'd1});
            start_c();
            send_byte(8'h24, "alt_wr_addr_ack", 1'b0);
            send_byte(8'(8'h80 + it), "alt_wr_ack", 1'b0);
            done_q.push_back({1'b0, 8'd1});
            start_c();
            send_byte(8'h25, "alt_rd_addr_ack", 1'b0);
            read_check(1'b1);
        end
        done_q.push_back({1'b1, 8'd1});
        stop_c();
        wq();
        check("alt_done_count", 32'(done_seen - n0), 32'd128);
        check("alt_rx_count", 32'(rx_count), 32'd96);
        for (int it = 0; it < 64; it++) begin
            rx_idx = 7'(32 + it);
            #1 check("alt_rx_mem", 32'(rx_data), 32'(8'h80 + it));
        end

        // Address mismatch
        n0 = done_seen;
        start_c();
        send_byte(8'h26, "mismatch_nack", 1'b1);
        send_byte(8'h55, "mismatch_data_nack", 1'b1);
        stop_c();
        wq(); wq();
        check("mismatch_rx_count", 32'(rx_count), 32'd96);
        check("mismatch_no_done", 32'(done_seen - n0), 32'd0);

        // Read with empty tx FIFO
        check("empty_tx_empty", 32'(tx_empty), 32'd1);
        rd_q.push_back(8'hFF);
        start_c();
        send_byte(8'h25, "empty_rd_addr_ack", 1'b0);
        read_check(1'b1);
        done_q.push_back({1'b1, 8'd1});
        stop_c();
        wq();

        // Reset while the slave drives a 0 data bit
        n0 = done_seen;
        push_tx(8'h00);
        start_c();
        send_byte(8'h25, "rst_rd_addr_ack", 1'b0);
        for (int i = 0; i < 3; i++) recv_bit(b);
        sda_m = 1'b1; wq();
        scl = 1'b1;   wq();
        check("pre_rst_sda_low", 32'(sda_bus), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_sda_o", 32'(sda_o), 32'd1);
        check("rst_mid_state", 32'(dut.state_q), 32'd0);
        check("rst_mid_rx_count", 32'(rx_count), 32'd0);
        check("rst_mid_tx_empty", 32'(tx_empty), 32'd1);
        check("rst_mid_xfer_op", 32'(xfer_op), 32'd0);
        check("rst_mid_xfer_len", 32'(xfer_len), 32'd0);
        wq();
        scl = 1'b0; wq();
        stop_c();
        wq();
        check("rst_mid_no_done", 32'(done_seen - n0), 32'd0);

        // 130 writes: rx_count saturates at 128, all bytes still ACKed
        start_c();
        send_byte(8'h24, "sat_addr_ack", 1'b0);
        for (int i = 0; i < 130; i++) send_byte(8'(i), "sat_wr_ack", 1'b0);
        done_q.push_back({1'b0, 8'd130});
        stop_c();
        wq();
        check("sat_rx_count", 32'(rx_count), 32'd128);
        rx_idx = 7'd127;
        #1 check("sat_rx_mem_127", 32'(rx_data), 32'd127);
        rx_idx = 7'd0;
        #1 check("sat_rx_mem_0", 32'(rx_data), 32'd0);

        repeat (10) wq();
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
